// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if
//   Bundles the write-back arbitration signals between the pipeline WB stage,
//   the long-latency unit (LU) and the register-file write port.
//   master : pipeline/LU side (drives requests, observes grant and RF port)
//   slave  : the arbiter (wb_port_arbiter)
//   Signals:
//     wb_valid/wb_rd/wb_data : WB-stage write request
//     lu_valid/lu_rd/lu_data : LU result offer
//     lu_ready               : arbiter accepts the LU result this cycle
//     rf_we/rf_waddr/rf_wdata: register-file write port (combinational)
//     pipe_stall             : freeze the WB stage and everything upstream
interface wb_port_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pipe_stall;

  modport master (
    output wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
    input  lu_ready, rf_we, rf_waddr, rf_wdata, pipe_stall
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
    output lu_ready, rf_we, rf_waddr, rf_wdata, pipe_stall
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares one register-file write port between the pipeline WB stage and a
//   long-latency unit. An LU result that cannot be written immediately is held
//   in a one-entry buffer until the port is free.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : wb_port_arbiter_if.slave (requests, lu_ready, RF port, pipe_stall)
//   Parameter:
//     STARVE_MAX : cycles a buffered result may lose the port before a forced
//                  stall (1..15); only meaningful with WB_ARB_STARVE_EN.
//   Configuration macro:
//     WB_ARB_STARVE_EN : when defined, a starvation counter forces a one-cycle
//                        pipeline stall to drain the buffer. When undefined,
//                        the buffer drains only on a cycle with no pipeline
//                        request and pipe_stall is tied 0.
//
//   state | meaning
//   EMPTY | buffer empty; LU may bypass straight to the port
//   WAIT  | buffer holds a result, losing to pipeline writes
//   FORCE | buffer starved STARVE_MAX cycles; write it and stall the pipeline
//   (state is derived from buf_valid_q and starve_cnt_q)
module wb_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_port_arbiter_if.slave   bus
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
    $error("wb_port_arbiter: STARVE_MAX must be 1..15");
  end

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
`ifdef WB_ARB_STARVE_EN
  localparam logic [1:0] ST_FORCE = 2'd2;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
`endif

  logic        buf_valid_q, buf_valid_d;
  logic [4:0]  buf_rd_q, buf_rd_d;
  logic [31:0] buf_data_q, buf_data_d;
`ifdef WB_ARB_STARVE_EN
  logic [3:0]  starve_cnt_q, starve_cnt_d;
`endif

  logic [1:0]  state;
  logic        wb_req;
  logic        lu_xfer;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pipe_stall;

  always_comb begin
    state = ST_EMPTY;
    if (buf_valid_q) begin
`ifdef WB_ARB_STARVE_EN
      state = (starve_cnt_q >= STARVE_LIM) ? ST_FORCE : ST_WAIT;
`else
      state = ST_WAIT;
`endif
    end
  end

  always_comb begin
    // Gating with rst_n keeps all outputs quiet during reset regardless of inputs.
    lu_ready   = rst_n & ~buf_valid_q;
    wb_req     = bus.wb_valid & (bus.wb_rd != 5'd0);
    lu_xfer    = bus.lu_valid & lu_ready;
    rf_we      = 1'b0;
    rf_waddr   = 5'd0;
    rf_wdata   = 32'd0;
    pipe_stall = 1'b0;
    buf_valid_d = buf_valid_q;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
`ifdef WB_ARB_STARVE_EN
    starve_cnt_d = starve_cnt_q;
`endif

    if (rst_n) begin
      case (state)
`ifdef WB_ARB_STARVE_EN
        ST_FORCE: begin
          rf_we        = 1'b1;
          rf_waddr     = buf_rd_q;
          rf_wdata     = buf_data_q;
          pipe_stall   = 1'b1;
          buf_valid_d  = 1'b0;
          starve_cnt_d = 4'd0;
        end
`endif
        ST_WAIT: begin
          if (wb_req) begin
            rf_we    = 1'b1;
            rf_waddr = bus.wb_rd;
            rf_wdata = bus.wb_data;
            if (bus.wb_rd == buf_rd_q) begin
              // Younger pipeline write to the same register: buffered value is dead.
              buf_valid_d = 1'b0;
`ifdef WB_ARB_STARVE_EN
              starve_cnt_d = 4'd0;
`endif
            end
`ifdef WB_ARB_STARVE_EN
            else begin
              starve_cnt_d = starve_cnt_q + 4'd1;
            end
`endif
          end else begin
            rf_we       = 1'b1;
            rf_waddr    = buf_rd_q;
            rf_wdata    = buf_data_q;
            buf_valid_d = 1'b0;
`ifdef WB_ARB_STARVE_EN
            starve_cnt_d = 4'd0;
`endif
          end
        end
        default: begin
          if (wb_req) begin
            rf_we    = 1'b1;
            rf_waddr = bus.wb_rd;
            rf_wdata = bus.wb_data;
            // rd=0 results are dropped; a same-rd LU result is already stale.
            if (lu_xfer && (bus.lu_rd != 5'd0) && (bus.lu_rd != bus.wb_rd)) begin
              buf_valid_d = 1'b1;
              buf_rd_d    = bus.lu_rd;
              buf_data_d  = bus.lu_data;
`ifdef WB_ARB_STARVE_EN
              starve_cnt_d = 4'd0;
`endif
            end
          end else if (lu_xfer && (bus.lu_rd != 5'd0)) begin
            rf_we    = 1'b1;
            rf_waddr = bus.lu_rd;
            rf_wdata = bus.lu_data;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
      buf_rd_q    <= 5'd0;
      buf_data_q  <= 32'd0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_rd_q    <= buf_rd_d;
      buf_data_q  <= buf_data_d;
    end
  end

`ifdef WB_ARB_STARVE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt_q <= 4'd0;
    else        starve_cnt_q <= starve_cnt_d;
  end
`endif

  assign bus.lu_ready   = lu_ready;
  assign bus.rf_we      = rf_we;
  assign bus.rf_waddr   = rf_waddr;
  assign bus.rf_wdata   = rf_wdata;
  assign bus.pipe_stall = pipe_stall;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
//   Directed bench for wb_port_arbiter with STARVE_MAX=4. Inputs change 1 time
//   unit after a rising edge; combinational outputs are checked 1 unit later.
module tb_wb_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_port(input string tag, input logic we, input logic [4:0] addr,
                             input logic [31:0] data, input logic stall, input logic rdy);
    check({tag, ".rf_we"},      32'(bus.rf_we),      32'(we));
    check({tag, ".rf_waddr"},   32'(bus.rf_waddr),   32'(addr));
    check({tag, ".rf_wdata"},   bus.rf_wdata,        data);
    check({tag, ".pipe_stall"}, 32'(bus.pipe_stall), 32'(stall));
    check({tag, ".lu_ready"},   32'(bus.lu_ready),   32'(rdy));
  endtask

  task automatic drive(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    bus.wb_valid = wv;
    bus.wb_rd    = wr;
    bus.wb_data  = wd;
    bus.lu_valid = lv;
    bus.lu_rd    = lr;
    bus.lu_data  = ld;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with active inputs: outputs must stay quiet.
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd5, 32'h55);
    expect_port("reset_busy", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // First cycle after release, LU offers rd=0: accepted, discarded.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF);
    expect_port("lu_rd0", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    idle();
    expect_port("lu_rd0_after", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

    // Bypass on idle port.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    expect_port("bypass", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1);
    tick();
    idle();
    expect_port("bypass_after", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

    // Conflict: pipeline wins, LU buffered, drained next idle cycle.
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h11);
    expect_port("conflict_wb", 1'b1, 5'd3, 32'h33, 1'b0, 1'b1);
    tick();
    idle();
    expect_port("conflict_drain", 1'b1, 5'd7, 32'h11, 1'b0, 1'b0);
    tick();
    expect_port("conflict_empty", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

    // Starvation: buffer rd=7, pipeline writes rd=1..4 then keeps requesting rd=5.
    drive(1'b1, 5'd20, 32'h14, 1'b1, 5'd7, 32'h77);
    expect_port("starve_load", 1'b1, 5'd20, 32'h14, 1'b0, 1'b1);
    tick();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0, 32'd0);
      expect_port($sformatf("starve_wb%0d", i), 1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 5'd5, 32'h105, 1'b0, 5'd0, 32'd0);
`ifdef WB_ARB_STARVE_EN
    expect_port("starve_force", 1'b1, 5'd7, 32'h77, 1'b1, 1'b0);
    tick();
    expect_port("starve_resume", 1'b1, 5'd5, 32'h105, 1'b0, 1'b1);
    tick();
    idle();
`else
    expect_port("starve_wb5", 1'b1, 5'd5, 32'h105, 1'b0, 1'b0);
    tick();
    idle();
    expect_port("starve_drain", 1'b1, 5'd7, 32'h77, 1'b0, 1'b0);
    tick();
`endif
    expect_port("starve_empty", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

    // WAW kill of buffered rd=9.
    drive(1'b1, 5'd20, 32'h14, 1'b1, 5'd9, 32'h99);
    tick();
    drive(1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'd0);
    expect_port("waw_wb", 1'b1, 5'd9, 32'h22, 1'b0, 1'b0);
    tick();
    idle();
    expect_port("waw_after1", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    expect_port("waw_after2", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

    // WAW kill on bypass: same rd as pipeline, LU result dropped.
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h55);
    expect_port("waw_byp_wb", 1'b1, 5'd6, 32'h66, 1'b0, 1'b1);
    tick();
    idle();
    expect_port("waw_byp_after", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

    // wb_rd=0 is no request: LU bypasses.
    drive(1'b1, 5'd0, 32'hBAD, 1'b1, 5'd8, 32'h88);
    expect_port("wbrd0_bypass", 1'b1, 5'd8, 32'h88, 1'b0, 1'b1);
    tick();

    // wb_rd=0 while buffered: buffer drains.
    drive(1'b1, 5'd21, 32'h15, 1'b1, 5'd10, 32'hAA);
    tick();
    drive(1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0, 32'd0);
    expect_port("wbrd0_drain", 1'b1, 5'd10, 32'hAA, 1'b0, 1'b0);
    tick();
    idle();
    expect_port("wbrd0_empty", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

    // Mid-cycle reset with rd=12 buffered: discarded, never written.
    drive(1'b1, 5'd22, 32'h16, 1'b1, 5'd12, 32'hCC);
    tick();
    drive(1'b1, 5'd2, 32'h02, 1'b0, 5'd0, 32'd0);
    expect_port("rst_pre", 1'b1, 5'd2, 32'h02, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    expect_port("rst_mid", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    expect_port("rst_release", 1'b1, 5'd2, 32'h02, 1'b0, 1'b1);
    tick();
    idle();
    expect_port("rst_after1", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    expect_port("rst_after2", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
